// File: rtl/dpram_op_sequencer_pkg.sv
// Shared definitions for the dual-port RAM operation sequencer: op codes,
// FSM state encodings and default geometry.
package dpram_op_sequencer_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_INC  = 3'd1,
    OP_FIB  = 3'd2,
    OP_FILL = 3'd3,
    OP_COPY = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Codes 5..7 are reserved and reported as errors.
  function automatic logic op_is_legal(input logic [2:0] code);
    return code <= 3'd4;
  endfunction

endpackage

// File: rtl/dpram_addr_gen.sv
// Operation pointer for the sequencer: latches base/len/destination, steps by 1 or 2,
// and provides the wrapped RAM addresses around the current word.
module dpram_addr_gen #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] base_in,
  input  logic [ADDR_W-1:0] dst_in,
  input  logic [ADDR_W:0]   len_in,
  input  logic [ADDR_W:0]   first_idx,
  input  logic              step,
  input  logic              step_two,
  output logic [ADDR_W-1:0] addr_cur,
  output logic [ADDR_W-1:0] addr_prev1,
  output logic [ADDR_W-1:0] addr_prev2,
  output logic [ADDR_W-1:0] addr_next,
  output logic [ADDR_W-1:0] addr_dst,
  output logic              last_one,
  output logic              last_two
);

  localparam logic [ADDR_W-1:0] ONE_A = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] TWO_A = {{(ADDR_W-2){1'b0}}, 2'b10};
  localparam logic [ADDR_W+1:0] ONE_W = {{(ADDR_W+1){1'b0}}, 1'b1};
  localparam logic [ADDR_W+1:0] TWO_W = {{ADDR_W{1'b0}}, 2'b10};

  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] dst_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   ptr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      base_q <= '0;
      dst_q  <= '0;
      len_q  <= '0;
      ptr_q  <= '0;
    end else if (load) begin
      base_q <= base_in;
      dst_q  <= dst_in;
      len_q  <= len_in;
      ptr_q  <= first_idx;
    end else if (step) begin
      ptr_q <= ptr_q + {{(ADDR_W-1){1'b0}}, step_two, ~step_two};
    end
  end

  // Address arithmetic is modulo the RAM depth, so ranges wrap naturally.
  always_comb begin
    addr_cur   = base_q + ptr_q[ADDR_W-1:0];
    addr_prev1 = addr_cur - ONE_A;
    addr_prev2 = addr_cur - TWO_A;
    addr_next  = addr_cur + ONE_A;
    addr_dst   = dst_q + ptr_q[ADDR_W-1:0];
    last_one   = ({1'b0, ptr_q} + ONE_W) >= {1'b0, len_q};
    last_two   = ({1'b0, ptr_q} + TWO_W) >= {1'b0, len_q};
  end

endmodule

// File: rtl/dpram_op_sequencer.sv
// Command-driven sequencer for the dual-port block RAM: accepts one INC/FIB/FILL/COPY
// operation over an address range and drives RAM ports A and B cycle by cycle.
module dpram_op_sequencer
  import dpram_op_sequencer_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   len,
  input  logic [DATA_W-1:0] arg,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic [DATA_W-1:0] din_a,
  output logic [DATA_W-1:0] din_b,
  output logic              wen_a,
  output logic              wen_b,
  input  logic [DATA_W-1:0] dout_a,
  input  logic [DATA_W-1:0] dout_b
);

  localparam logic [ADDR_W:0]   MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   FIB_MIN = {{(ADDR_W-1){1'b0}}, 2'b11};
  localparam logic [ADDR_W:0]   FIB_IDX = {{(ADDR_W-1){1'b0}}, 2'b10};
  localparam logic [DATA_W-1:0] ONE_D   = {{(DATA_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  op_e               op_q;
  logic [DATA_W-1:0] arg_q;
  logic              err_q;

  logic              legal, skip, accept;
  logic              step, step_two;
  logic [ADDR_W-1:0] addr_cur, addr_prev1, addr_prev2, addr_next, addr_dst;
  logic              last_one, last_two;

  assign busy   = (state_q == ST_RD) || (state_q == ST_WR);
  assign done   = (state_q == ST_DONE);
  assign err    = err_q;
  assign accept = start && !busy;
  assign legal  = op_is_legal(op) && (len <= MAX_LEN);
  // Commands with nothing to write go straight to DONE without touching the RAM.
  assign skip   = !legal || (op == OP_NOP) || (len == '0) ||
                  ((op == OP_FIB) && (len < FIB_MIN));

  dpram_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk        (clk),
    .reset      (reset),
    .load       (accept),
    .base_in    (base),
    .dst_in     (arg[ADDR_W-1:0]),
    .len_in     (len),
    .first_idx  ((op == OP_FIB) ? FIB_IDX : '0),
    .step       (step),
    .step_two   (step_two),
    .addr_cur   (addr_cur),
    .addr_prev1 (addr_prev1),
    .addr_prev2 (addr_prev2),
    .addr_next  (addr_next),
    .addr_dst   (addr_dst),
    .last_one   (last_one),
    .last_two   (last_two)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NOP;
      arg_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= legal ? op_e'(op) : OP_NOP;
        arg_q <= arg;
        err_q <= !legal;
      end
    end
  end

  // FILL lives in WR and advances two words per cycle; the others alternate RD/WR.
  always_comb begin
    state_d  = state_q;
    step     = 1'b0;
    step_two = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start)
          state_d = skip ? ST_DONE : ((op == OP_FILL) ? ST_WR : ST_RD);
        else
          state_d = ST_IDLE;
      end
      ST_RD: state_d = ST_WR;
      ST_WR: begin
        if (op_q == OP_FILL) begin
          if (last_two) begin
            state_d = ST_DONE;
          end else begin
            step     = 1'b1;
            step_two = 1'b1;
          end
        end else if (last_one) begin
          state_d = ST_DONE;
        end else begin
          step    = 1'b1;
          state_d = ST_RD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    addr_a = '0;
    addr_b = '0;
    din_a  = '0;
    din_b  = '0;
    wen_a  = 1'b0;
    wen_b  = 1'b0;
    if (state_q == ST_RD) begin
      case (op_q)
        OP_INC, OP_COPY: addr_a = addr_cur;
        OP_FIB: begin
          addr_a = addr_prev2;
          addr_b = addr_prev1;
        end
        default: ;
      endcase
    end else if (state_q == ST_WR) begin
      case (op_q)
        OP_INC: begin
          addr_a = addr_cur;
          din_a  = dout_a + ONE_D;
          wen_a  = 1'b1;
        end
        OP_FIB: begin
          addr_a = addr_cur;
          din_a  = dout_a + dout_b;
          wen_a  = 1'b1;
        end
        OP_FILL: begin
          addr_a = addr_cur;
          din_a  = arg_q;
          wen_a  = 1'b1;
          if (!last_one) begin
            addr_b = addr_next;
            din_b  = arg_q;
            wen_b  = 1'b1;
          end
        end
        OP_COPY: begin
          addr_b = addr_dst;
          din_b  = dout_a;
          wen_b  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dpram_op_sequencer.sv
// Self-checking bench for dpram_op_sequencer: behavioural dual-port RAM plus an
// array-level reference model of each operation, directed and randomized commands.
module tb_dpram_op_sequencer;

  localparam int AW    = 10;
  localparam int DW    = 16;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [2:0]    op;
  logic [AW-1:0] base;
  logic [AW:0]   len;
  logic [DW-1:0] arg;
  logic          busy, done, err;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] din_a, din_b, dout_a, dout_b;
  logic          wen_a, wen_b;

  logic [DW-1:0] mem      [DEPTH];
  logic [DW-1:0] init_mem [DEPTH];
  logic [DW-1:0] ref_mem  [DEPTH];
  logic          load_req = 1'b0;

  int pass_cnt  = 0;
  int total_cnt = 0;

  int busy_cycles, done_at, wen_cycles;
  bit saw_wen_b, conflict, last_wen_b, err_seen;

  always #5 clk = ~clk;

  dpram_op_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .base(base), .len(len), .arg(arg),
    .busy(busy), .done(done), .err(err),
    .addr_a(addr_a), .addr_b(addr_b), .din_a(din_a), .din_b(din_b),
    .wen_a(wen_a), .wen_b(wen_b), .dout_a(dout_a), .dout_b(dout_b)
  );

  // Synchronous-read dual-port RAM with a one-cycle bulk preload port.
  always @(posedge clk) begin
    if (load_req) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= init_mem[k];
    end else begin
      if (wen_a) mem[addr_a] <= din_a;
      if (wen_b) mem[addr_b] <= din_b;
    end
    dout_a <= mem[addr_a];
    dout_b <= mem[addr_b];
  end

  function automatic int mem_diffs();
    int n = 0;
    for (int k = 0; k < DEPTH; k++) if (mem[k] !== ref_mem[k]) n++;
    return n;
  endfunction

  task automatic randomize_init();
    for (int k = 0; k < DEPTH; k++) init_mem[k] = DW'($urandom);
  endtask

  task automatic load_mem();
    for (int k = 0; k < DEPTH; k++) ref_mem[k] = init_mem[k];
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  // Array-level meaning of each command; returns expected busy length and err.
  task automatic model_op(input logic [2:0] o, input int l, input int b, input logic [DW-1:0] a,
                          output int exp_busy, output bit exp_err);
    automatic bit legal = (o <= 3'd4) && (l <= DEPTH);
    automatic int dst = int'(a) % DEPTH;
    exp_err  = !legal;
    exp_busy = 0;
    if (!legal) return;
    case (o)
      3'd1: begin
        for (int i = 0; i < l; i++) ref_mem[(b + i) % DEPTH] = ref_mem[(b + i) % DEPTH] + 1'b1;
        exp_busy = 2 * l;
      end
      3'd2: if (l >= 3) begin
        for (int i = 2; i < l; i++)
          ref_mem[(b + i) % DEPTH] = ref_mem[(b + i - 2) % DEPTH] + ref_mem[(b + i - 1) % DEPTH];
        exp_busy = 2 * (l - 2);
      end
      3'd3: begin
        for (int i = 0; i < l; i++) ref_mem[(b + i) % DEPTH] = a;
        exp_busy = (l + 1) / 2;
      end
      3'd4: begin
        for (int i = 0; i < l; i++) ref_mem[(dst + i) % DEPTH] = ref_mem[(b + i) % DEPTH];
        exp_busy = 2 * l;
      end
      default: ;
    endcase
  endtask

  // Called at a negedge; issues start immediately and returns at the negedge of DONE.
  task automatic run_op(input logic [2:0] o, input logic [AW:0] l, input logic [AW-1:0] b,
                        input logic [DW-1:0] a);
    start = 1'b1; op = o; len = l; base = b; arg = a;
    @(negedge clk);
    start = 1'b0;
    busy_cycles = 0; done_at = -1; wen_cycles = 0;
    saw_wen_b = 0; conflict = 0; last_wen_b = 0; err_seen = 0;
    for (int c = 1; c <= 5000; c++) begin
      if (busy) begin
        busy_cycles++;
        last_wen_b = wen_b;
      end
      if (wen_a || wen_b) wen_cycles++;
      if (wen_b) saw_wen_b = 1;
      if (wen_a && wen_b && addr_a == addr_b) conflict = 1;
      if (done) begin
        done_at  = c;
        err_seen = err;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; op = 3'd1; len = 11'd5; base = '0; arg = '0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({busy, done, err, wen_a, wen_b} !== 5'b0) $display("[TB] FAIL reset_flags: got %b expected 00000", {busy, done, err, wen_a, wen_b});
    else pass_cnt++;
    total_cnt++;
    if ({addr_a, addr_b, din_a, din_b} !== '0) $display("[TB] FAIL reset_ports: got %h expected 0", {addr_a, addr_b, din_a, din_b});
    else pass_cnt++;
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0 || done !== 1'b0) $display("[TB] FAIL reset_beats_start: got busy=%b done=%b expected 0 0", busy, done);
    else pass_cnt++;
  endtask

  task automatic test_inc();
    int eb; bit ee;
    randomize_init();
    for (int k = 0; k <= 10; k++) init_mem[k] = DW'(k);
    load_mem();
    model_op(3'd1, 11, 0, '0, eb, ee);
    run_op(3'd1, 11'd11, 10'd0, '0);
    total_cnt++;
    if (busy_cycles !== 22) $display("[TB] FAIL inc_busy: got %0d expected 22", busy_cycles); else pass_cnt++;
    total_cnt++;
    if (done_at !== 23) $display("[TB] FAIL inc_done_at: got %0d expected 23", done_at); else pass_cnt++;
    total_cnt++;
    if (mem[5] !== 16'd6 || mem[10] !== 16'd11) $display("[TB] FAIL inc_values: got %0d,%0d expected 6,11", mem[5], mem[10]); else pass_cnt++;
    total_cnt++;
    if (mem_diffs() !== 0) $display("[TB] FAIL inc_mem: got %0d differing words expected 0", mem_diffs()); else pass_cnt++;
    total_cnt++;
    if (err_seen !== 1'b0) $display("[TB] FAIL inc_err: got %b expected 0", err_seen); else pass_cnt++;
  endtask

  task automatic test_fib();
    int eb; bit ee; int bad;
    int fib_exp [8];
    fib_exp = '{0, 1, 1, 2, 3, 5, 8, 13};
    randomize_init();
    init_mem[0] = 16'd0; init_mem[1] = 16'd1;
    load_mem();
    model_op(3'd2, 8, 0, '0, eb, ee);
    run_op(3'd2, 11'd8, 10'd0, '0);
    bad = 0;
    for (int k = 0; k < 8; k++) if (mem[k] !== DW'(fib_exp[k])) bad++;
    total_cnt++;
    if (bad !== 0) $display("[TB] FIB FAIL fib_values: got %0d wrong words expected 0", bad); else pass_cnt++;
    total_cnt++;
    if (busy_cycles !== 12) $display("[TB] FAIL fib_busy: got %0d expected 12", busy_cycles); else pass_cnt++;
    total_cnt++;
    if (saw_wen_b !== 1'b0) $display("[TB] FAIL fib_wen_b: got %b expected 0", saw_wen_b); else pass_cnt++;
    total_cnt++;
    if (mem_diffs() !== 0) $display("[TB] FAIL fib_mem: got %0d differing words expected 0", mem_diffs()); else pass_cnt++;
  endtask

  task automatic test_fill();
    int eb; bit ee;
    randomize_init();
    load_mem();
    model_op(3'd3, 7, 1020, 16'hA5A5, eb, ee);
    run_op(3'd3, 11'd7, 10'd1020, 16'hA5A5);
    total_cnt++;
    if (busy_cycles !== 4) $display("[TB] FAIL fill_busy: got %0d expected 4", busy_cycles); else pass_cnt++;
    total_cnt++;
    if (last_wen_b !== 1'b0) $display("[TB] FAIL fill_last_wen_b: got %b expected 0", last_wen_b); else pass_cnt++;
    total_cnt++;
    if (mem[3] !== init_mem[3]) $display("[TB] FAIL fill_mem3: got %h expected %h", mem[3], init_mem[3]); else pass_cnt++;
    total_cnt++;
    if (mem[1023] !== 16'hA5A5 || mem[2] !== 16'hA5A5) $display("[TB] FAIL fill_wrap: got %h,%h expected a5a5,a5a5", mem[1023], mem[2]); else pass_cnt++;
    total_cnt++;
    if (mem_diffs() !== 0) $display("[TB] FAIL fill_mem: got %0d differing words expected 0", mem_diffs()); else pass_cnt++;
  endtask

  task automatic test_copy();
    int eb; bit ee;
    randomize_init();
    init_mem[0] = 16'd11; init_mem[1] = 16'd22; init_mem[2] = 16'd33; init_mem[3] = 16'd44;
    load_mem();
    model_op(3'd4, 4, 0, 16'd100, eb, ee);
    run_op(3'd4, 11'd4, 10'd0, 16'd100);
    total_cnt++;
    if ({mem[100], mem[101], mem[102], mem[103]} !== {16'd11, 16'd22, 16'd33, 16'd44})
      $display("[TB] FAIL copy_dst: got %0d,%0d,%0d,%0d expected 11,22,33,44", mem[100], mem[101], mem[102], mem[103]);
    else pass_cnt++;
    total_cnt++;
    if ({mem[0], mem[3]} !== {16'd11, 16'd44}) $display("[TB] FAIL copy_src: got %0d,%0d expected 11,44", mem[0], mem[3]); else pass_cnt++;
    total_cnt++;
    if (busy_cycles !== 8) $display("[TB] FAIL copy_busy: got %0d expected 8", busy_cycles); else pass_cnt++;
    total_cnt++;
    if (mem_diffs() !== 0) $display("[TB] FAIL copy_mem: got %0d differing words expected 0", mem_diffs()); else pass_cnt++;
  endtask

  task automatic test_degenerate();
    logic [2:0] dg_op  [5];
    int         dg_len [5];
    bit         dg_err [5];
    dg_op  = '{3'd1, 3'd6, 3'd1, 3'd2, 3'd0};
    dg_len = '{0, 5, 1025, 2, 9};
    dg_err = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int t = 0; t < 5; t++) begin
      run_op(dg_op[t], (AW+1)'(dg_len[t]), 10'd7, 16'd3);
      total_cnt++;
      if (done_at !== 1 || wen_cycles !== 0)
        $display("[TB] FAIL degen_%0d_timing: got done_at=%0d writes=%0d expected 1 0", t, done_at, wen_cycles);
      else pass_cnt++;
      total_cnt++;
      if (err_seen !== dg_err[t]) $display("[TB] FAIL degen_%0d_err: got %b expected %b", t, err_seen, dg_err[t]); else pass_cnt++;
    end
    run_op(3'd7, 11'd1, 10'd0, '0);
    @(negedge clk);
    total_cnt++;
    if (err !== 1'b1 || busy !== 1'b0) $display("[TB] FAIL err_held: got err=%b busy=%b expected 1 0", err, busy); else pass_cnt++;
    total_cnt++;
    if (mem_diffs() !== 0) $display("[TB] FAIL degen_mem: got %0d differing words expected 0", mem_diffs()); else pass_cnt++;
  endtask

  task automatic test_start_held_and_reset();
    int writes; bit dropped; int eb; bit ee;
    randomize_init();
    for (int k = 0; k <= 10; k++) init_mem[k] = DW'(k);
    load_mem();
    start = 1'b1; op = 3'd1; base = 10'd0; len = 11'd11; arg = '0;
    @(negedge clk);
    op = 3'd3; base = 10'd500; len = 11'd5; arg = 16'hFFFF;
    writes = 0; dropped = 0;
    for (int c = 0; c < 200; c++) begin
      if (!busy) dropped = 1;
      if (wen_a) writes++;
      if (writes == 3) break;
      @(negedge clk);
    end
    total_cnt++;
    if (writes !== 3 || dropped !== 1'b0) $display("[TB] FAIL held_start: got writes=%0d dropped=%b expected 3 0", writes, dropped); else pass_cnt++;
    reset = 1'b1; start = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({busy, wen_a, wen_b} !== 3'b000) $display("[TB] FAIL reset_abort: got busy,wen_a,wen_b=%b expected 000", {busy, wen_a, wen_b}); else pass_cnt++;
    for (int k = 0; k < 3; k++) ref_mem[k] = ref_mem[k] + 1'b1;
    total_cnt++;
    if (mem_diffs() !== 0) $display("[TB] FAIL abort_mem: got %0d differing words expected 0", mem_diffs()); else pass_cnt++;
    reset = 1'b0;
    model_op(3'd1, 2, 3, '0, eb, ee);
    run_op(3'd1, 11'd2, 10'd3, '0);
    total_cnt++;
    if (done_at !== 5 || mem[3] !== 16'd4 || mem[4] !== 16'd5)
      $display("[TB] FAIL after_reset: got done_at=%0d mem3=%0d mem4=%0d expected 5 4 5", done_at, mem[3], mem[4]);
    else pass_cnt++;
  endtask

  // Random commands issued back to back; each start lands in the previous DONE cycle.
  task automatic test_random();
    logic [2:0] o; int l; int b; logic [DW-1:0] a; int eb; bit ee; int r;
    randomize_init();
    load_mem();
    for (int it = 0; it < 25; it++) begin
      o = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(1, 4)) : 3'($urandom_range(0, 7));
      r = $urandom_range(0, 9);
      l = (r == 0) ? 0 : (r == 1) ? 1024 + $urandom_range(0, 2) : $urandom_range(1, 40);
      b = $urandom_range(0, DEPTH - 1);
      a = DW'($urandom);
      model_op(o, l, b, a, eb, ee);
      run_op(o, (AW+1)'(l), AW'(b), a);
      total_cnt++;
      if (done_at !== eb + 1 || busy_cycles !== eb)
        $display("[TB] FAIL rand_%0d_timing op=%0d len=%0d: got done_at=%0d busy=%0d expected %0d %0d", it, o, l, done_at, busy_cycles, eb + 1, eb);
      else pass_cnt++;
      total_cnt++;
      if (err_seen !== ee) $display("[TB] FAIL rand_%0d_err: got %b expected %b", it, err_seen, ee); else pass_cnt++;
      total_cnt++;
      if (conflict !== 1'b0) $display("[TB] FAIL rand_%0d_conflict: got %b expected 0", it, conflict); else pass_cnt++;
      total_cnt++;
      if (mem_diffs() !== 0) $display("[TB] FAIL rand_%0d_mem op=%0d len=%0d base=%0d: got %0d differing words expected 0", it, o, l, b, mem_diffs()); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    $display("[TB] reset done");
    test_inc();
    test_fib();
    test_fill();
    test_copy();
    test_degenerate();
    test_start_held_and_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
